// File: rtl/usr_param_frame.sv
// Universal shift register (hold/shift/load/rotate/ASR) with an autonomous
// PISO framer that streams a loaded word LSB-first on so_r.
module usr_param_frame #(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             si_r,
    input  logic             si_l,
    input  logic [WIDTH-1:0] pi,
    input  logic             start,
    output logic [WIDTH-1:0] po,
    output logic             so_r,
    output logic             so_l,
    output logic             busy,
    output logic             done
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_po;
    logic             r_done;
    logic [WIDTH-1:0] w_po_mode;
    logic [WIDTH-1:0] w_po_shr;

    always_comb begin
        w_po_mode = r_po;
        case (mode)
            3'b001:  w_po_mode = {si_r, r_po[WIDTH-1:1]};
            3'b010:  w_po_mode = {r_po[WIDTH-2:0], si_l};
            3'b011:  w_po_mode = pi;
            3'b100:  w_po_mode = {r_po[0], r_po[WIDTH-1:1]};
            3'b101:  w_po_mode = {r_po[WIDTH-2:0], r_po[WIDTH-1]};
            3'b110:  w_po_mode = {r_po[WIDTH-1], r_po[WIDTH-1:1]};
            default: w_po_mode = r_po;
        endcase
    end

    assign w_po_shr = {si_r, r_po[WIDTH-1:1]};

    // done is cleared every cycle regardless of en so it is always a single pulse
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_po    <= RST_VAL;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (en) begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_po    <= pi;
                            r_cnt   <= CNT_LAST;
                            r_state <= S_SHIFT;
                        end else begin
                            r_po <= w_po_mode;
                        end
                    end
                    S_SHIFT: begin
                        r_po <= w_po_shr;
                        if (r_cnt == '0) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign po   = r_po;
    assign so_r = r_po[0];
    assign so_l = r_po[WIDTH-1];
    assign busy = (r_state == S_SHIFT);
    assign done = r_done;

endmodule

// File: tb/tb_usr_param_frame.sv
// Directed scoreboard bench for usr_param_frame (WIDTH=8), plus a second
// instance with RST_VAL=8'h3C to check the reset value parameter.
module tb_usr_param_frame;

    logic       clk = 1'b0;
    logic       clr, en, si_r, si_l, start;
    logic [2:0] mode;
    logic [7:0] pi;
    logic [7:0] po, po2;
    logic       so_r, so_l, busy, done;
    logic       so_r2, so_l2, busy2, done2;

    always #5 clk = ~clk;

    usr_param_frame #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .clr(clr), .en(en), .mode(mode), .si_r(si_r), .si_l(si_l),
        .pi(pi), .start(start), .po(po), .so_r(so_r), .so_l(so_l),
        .busy(busy), .done(done)
    );

    usr_param_frame #(.WIDTH(8), .RST_VAL(8'h3C)) dut_rv (
        .clk(clk), .clr(clr), .en(en), .mode(mode), .si_r(si_r), .si_l(si_l),
        .pi(pi), .start(start), .po(po2), .so_r(so_r2), .so_l(so_l2),
        .busy(busy2), .done(done2)
    );

    typedef struct {
        string      tag;
        int         sig;
        logic [7:0] want;
    } exp_t;

    localparam int SIG_PO = 0, SIG_SOR = 1, SIG_SOL = 2, SIG_BUSY = 3, SIG_DONE = 4, SIG_PO2 = 5;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [7:0] observe(int sig);
        case (sig)
            SIG_PO:   return po;
            SIG_SOR:  return {7'b0, so_r};
            SIG_SOL:  return {7'b0, so_l};
            SIG_BUSY: return {7'b0, busy};
            SIG_DONE: return {7'b0, done};
            default:  return po2;
        endcase
    endfunction

    task automatic push(string tag, int sig, logic [7:0] want);
        exp_t e;
        e.tag  = tag;
        e.sig  = sig;
        e.want = want;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            n_tests++;
            assert (obs === e.want) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.want);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic push_bit(string tag, logic [7:0] w, int k);
        push(tag, SIG_SOR, {7'b0, w[k]});
        push({tag, "_busy"}, SIG_BUSY, 8'h01);
        push({tag, "_done"}, SIG_DONE, 8'h00);
    endtask

    initial begin
        clr = 1'b0; en = 1'b0; si_r = 1'b0; si_l = 1'b0; start = 1'b0;
        mode = 3'b000; pi = 8'h00;

        // async reset mid-cycle, observed before any clock edge
        #7 clr = 1'b1;
        #1;
        push("rst_po",    SIG_PO,   8'h00);
        push("rst_busy",  SIG_BUSY, 8'h00);
        push("rst_done",  SIG_DONE, 8'h00);
        push("rst_po_rv", SIG_PO2,  8'h3C);
        drain();
        #2 clr = 1'b0;
        @(posedge clk);
        #1;

        // load and shifts
        en = 1'b1; mode = 3'b011; pi = 8'h96;
        push("load96", SIG_PO, 8'h96); tick();
        mode = 3'b001; si_r = 1'b1;
        push("shr1", SIG_PO, 8'hCB); tick();
        push("shr2", SIG_PO, 8'hE5); tick();
        mode = 3'b010; si_l = 1'b0;
        push("shl", SIG_PO, 8'hCA);
        push("shl_sor", SIG_SOR, 8'h00);
        push("shl_sol", SIG_SOL, 8'h01);
        tick();

        // rotates, ASR, reserved/hold
        si_r = 1'b0;
        mode = 3'b011; pi = 8'h81; push("load81a", SIG_PO, 8'h81); tick();
        mode = 3'b100; push("rotr", SIG_PO, 8'hC0); tick();
        mode = 3'b011; pi = 8'h81; push("load81b", SIG_PO, 8'h81); tick();
        mode = 3'b101; push("rotl1", SIG_PO, 8'h03); tick();
        push("rotl2", SIG_PO, 8'h06); tick();
        mode = 3'b011; pi = 8'h80; push("load80", SIG_PO, 8'h80); tick();
        mode = 3'b110; push("asr", SIG_PO, 8'hC0); tick();
        mode = 3'b111; push("rsvd_hold", SIG_PO, 8'hC0); tick();
        mode = 3'b000; push("hold", SIG_PO, 8'hC0); tick();
        en = 1'b0; mode = 3'b011; pi = 8'hFF; start = 1'b1;
        push("en0_po", SIG_PO, 8'hC0);
        push("en0_busy", SIG_BUSY, 8'h00);
        tick();

        // basic frame, mode toggled while busy
        en = 1'b1; start = 1'b1; pi = 8'hA5; mode = 3'b000; si_r = 1'b0;
        push_bit("f1_b0", 8'hA5, 0); tick();
        start = 1'b0; pi = 8'h3F;
        for (int k = 1; k < 8; k++) begin
            mode = 3'(k);
            push_bit($sformatf("f1_b%0d", k), 8'hA5, k);
            tick();
        end
        mode = 3'b000;
        push("f1_done", SIG_DONE, 8'h01);
        push("f1_idle", SIG_BUSY, 8'h00);
        push("f1_po_end", SIG_PO, 8'h00);
        tick();
        push("f1_done_clr", SIG_DONE, 8'h00); tick();

        // frame with a 3-cycle stall after bit 2; done falls even with en=0
        start = 1'b1; pi = 8'h6B;
        push_bit("f2_b0", 8'h6B, 0); tick();
        start = 1'b0;
        push_bit("f2_b1", 8'h6B, 1); tick();
        push_bit("f2_b2", 8'h6B, 2); tick();
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            push_bit($sformatf("f2_stall%0d", s), 8'h6B, 2);
            tick();
        end
        en = 1'b1;
        for (int k = 3; k < 8; k++) begin
            push_bit($sformatf("f2_b%0d", k), 8'h6B, k);
            tick();
        end
        push("f2_done", SIG_DONE, 8'h01);
        push("f2_idle", SIG_BUSY, 8'h00);
        tick();
        en = 1'b0;
        push("f2_done_en0", SIG_DONE, 8'h00); tick();
        en = 1'b1;

        // clr aborts a frame at bit 4
        start = 1'b1; pi = 8'hC3;
        push_bit("f3_b0", 8'hC3, 0); tick();
        start = 1'b0;
        for (int k = 1; k < 5; k++) begin
            push_bit($sformatf("f3_b%0d", k), 8'hC3, k);
            tick();
        end
        #2 clr = 1'b1;
        #1;
        push("abort_busy", SIG_BUSY, 8'h00);
        push("abort_done", SIG_DONE, 8'h00);
        push("abort_po", SIG_PO, 8'h00);
        drain();
        #2 clr = 1'b0;
        push("abort_nodone", SIG_DONE, 8'h00);
        push("abort_idle", SIG_BUSY, 8'h00);
        tick();

        // start held through done: second frame follows the done cycle directly
        start = 1'b1; pi = 8'hA5;
        push_bit("f4_b0", 8'hA5, 0); tick();
        pi = 8'h5A;
        for (int k = 1; k < 8; k++) begin
            push_bit($sformatf("f4_b%0d", k), 8'hA5, k);
            tick();
        end
        push("f4_done", SIG_DONE, 8'h01);
        push("f4_idle", SIG_BUSY, 8'h00);
        tick();
        push_bit("f5_b0", 8'h5A, 0); tick();
        start = 1'b0;
        for (int k = 1; k < 8; k++) begin
            push_bit($sformatf("f5_b%0d", k), 8'h5A, k);
            tick();
        end
        push("f5_done", SIG_DONE, 8'h01); tick();
        push("f5_done_clr", SIG_DONE, 8'h00); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
